// File: rtl/arcade_game_selector.sv
// arcade_game_selector: N-slot game menu with key-driven cursor, start/done launch handshake and VGA mux.
// Optional feature macro SELECTOR_WRAP_EN: cursor wraps at both ends instead of saturating.
module arcade_game_selector #(
    parameter int NUM_GAMES = 4,
    parameter int COLOR_W   = 4,
    parameter int SLOT_H    = 48,
    parameter int MENU_Y0   = 64
) (
    input  logic                             CLK,
    input  logic                             RST_BTN,
    input  logic [9:0]                       x,
    input  logic [8:0]                       y,
    input  logic                             key_up_n,
    input  logic                             key_down_n,
    input  logic                             key_sel_n,
    input  logic                             key_back_n,
    input  logic [NUM_GAMES-1:0]             game_done,
    input  logic [NUM_GAMES*3*COLOR_W-1:0]   game_rgb,
    output logic [NUM_GAMES-1:0]             game_start,
    output logic [2:0]                       cur_sel,
    output logic [COLOR_W-1:0]               vga_r,
    output logic [COLOR_W-1:0]               vga_g,
    output logic [COLOR_W-1:0]               vga_b
);

    localparam int PIX_W = 3 * COLOR_W;
    localparam logic [1:0] ST_MENU   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_EXIT   = 2'd3;
    localparam logic [2:0] LAST_IDX  = 3'(NUM_GAMES - 1);
    localparam logic [PIX_W-1:0] MENU_BLUE = {{(PIX_W-1){1'b0}}, 1'b1} << (COLOR_W - 1);
    localparam int K_UP   = 0;
    localparam int K_DOWN = 1;
    localparam int K_SEL  = 2;
    localparam int K_BACK = 3;

    logic [3:0]            key_raw_s;
    logic [3:0]            sync1_r;
    logic [3:0]            sync2_r;
    logic [3:0]            prev_r;
    logic [3:0]            press_s;
    logic [1:0]            state_r;
    logic [1:0]            state_nx_s;
    logic [2:0]            cursor_r;
    logic [2:0]            cursor_nx_s;
    logic [2:0]            cursor_up_s;
    logic [2:0]            cursor_down_s;
    logic [NUM_GAMES-1:0]  cur_onehot_s;
    logic [NUM_GAMES-1:0]  slot_hit_s;
    logic [NUM_GAMES-1:0]  game_start_r;
    logic                  done_sel_s;
    logic                  x_in_s;
    logic [PIX_W-1:0]      rgb_sel_s;
    logic [PIX_W-1:0]      pix_s;
    logic [PIX_W-1:0]      pix_r;

    assign key_raw_s = {key_back_n, key_sel_n, key_down_n, key_up_n};
    assign press_s   = prev_r & ~sync2_r;

    // Key synchroniser and previous-level register; released (1) out of reset
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            sync1_r <= 4'b1111;
            sync2_r <= 4'b1111;
            prev_r  <= 4'b1111;
        end else begin
            sync1_r <= key_raw_s;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign cur_onehot_s = {{(NUM_GAMES-1){1'b0}}, 1'b1} << cursor_r;
    assign done_sel_s   = |(game_done & cur_onehot_s);

`ifdef SELECTOR_WRAP_EN
    assign cursor_up_s   = (cursor_r == 3'd0)     ? LAST_IDX : cursor_r - 3'd1;
    assign cursor_down_s = (cursor_r == LAST_IDX) ? 3'd0     : cursor_r + 3'd1;
`else
    assign cursor_up_s   = (cursor_r == 3'd0)     ? 3'd0     : cursor_r - 3'd1;
    assign cursor_down_s = (cursor_r == LAST_IDX) ? LAST_IDX : cursor_r + 3'd1;
`endif

    assign x_in_s = (x >= 10'd160) && (x < 10'd480);
    for (genvar gi = 0; gi < NUM_GAMES; gi++) begin : g_slot
        localparam int SLOT_LO = MENU_Y0 + gi * SLOT_H;
        localparam int SLOT_HI = SLOT_LO + SLOT_H - 8;
        assign slot_hit_s[gi] = x_in_s && (int'(y) >= SLOT_LO) && (int'(y) < SLOT_HI);
    end

    // Colour slice of the game under the cursor
    always_comb begin
        rgb_sel_s = {PIX_W{1'b0}};
        for (int i = 0; i < NUM_GAMES; i++) begin
            rgb_sel_s = rgb_sel_s | (game_rgb[i*PIX_W +: PIX_W] & {PIX_W{cur_onehot_s[i]}});
        end
    end

    // Menu / launch / run / exit sequencing and cursor movement
    always_comb begin
        state_nx_s  = state_r;
        cursor_nx_s = cursor_r;
        case (state_r)
            ST_MENU: begin
                if (press_s[K_SEL]) begin
                    state_nx_s = ST_LAUNCH;
                end else if (press_s[K_UP] && !press_s[K_DOWN]) begin
                    cursor_nx_s = cursor_up_s;
                end else if (press_s[K_DOWN] && !press_s[K_UP]) begin
                    cursor_nx_s = cursor_down_s;
                end else begin
                    cursor_nx_s = cursor_r;
                end
            end
            ST_LAUNCH: begin
                if (sync2_r[K_SEL]) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_LAUNCH;
                end
            end
            ST_RUN: begin
                if (done_sel_s || press_s[K_BACK]) begin
                    state_nx_s = ST_EXIT;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_EXIT: begin
                if (!done_sel_s && (&sync2_r)) begin
                    state_nx_s = ST_MENU;
                end else begin
                    state_nx_s = ST_EXIT;
                end
            end
            default: begin
                state_nx_s  = ST_MENU;
                cursor_nx_s = 3'd0;
            end
        endcase
    end

    // Pixel source: menu slots, running game, or black while launching/exiting
    always_comb begin
        pix_s = {PIX_W{1'b0}};
        case (state_r)
            ST_MENU: begin
                if (|(slot_hit_s & cur_onehot_s)) begin
                    pix_s = {PIX_W{1'b1}};
                end else if (|slot_hit_s) begin
                    pix_s = MENU_BLUE;
                end else begin
                    pix_s = {PIX_W{1'b0}};
                end
            end
            ST_RUN:  pix_s = rgb_sel_s;
            default: pix_s = {PIX_W{1'b0}};
        endcase
    end

    // State, cursor, run enable and video registers; game_start follows the next state
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            state_r      <= ST_MENU;
            cursor_r     <= 3'd0;
            game_start_r <= {NUM_GAMES{1'b0}};
            pix_r        <= {PIX_W{1'b0}};
        end else begin
            state_r      <= state_nx_s;
            cursor_r     <= cursor_nx_s;
            game_start_r <= (state_nx_s == ST_RUN) ? cur_onehot_s : {NUM_GAMES{1'b0}};
            pix_r        <= pix_s;
        end
    end

    assign game_start = game_start_r;
    assign cur_sel    = cursor_r;
    assign vga_r      = pix_r[PIX_W-1 -: COLOR_W];
    assign vga_g      = pix_r[2*COLOR_W-1 -: COLOR_W];
    assign vga_b      = pix_r[COLOR_W-1:0];

endmodule

// File: tb/tb_arcade_game_selector.sv
// Self-checking bench for arcade_game_selector: video expectations go through a scoreboard queue.
module tb_arcade_game_selector;

    localparam int NG = 4;
    localparam int CW = 4;

    logic              CLK = 1'b0;
    logic              RST_BTN;
    logic [9:0]        x;
    logic [8:0]        y;
    logic [3:0]        keys_n;
    logic [NG-1:0]     game_done;
    logic [NG*12-1:0]  game_rgb;
    logic [NG-1:0]     game_start;
    logic [2:0]        cur_sel;
    logic [CW-1:0]     vga_r;
    logic [CW-1:0]     vga_g;
    logic [CW-1:0]     vga_b;

    int          vectors = 0;
    int          miscompares = 0;
    logic [11:0] sb_q[$];
    logic [11:0] exp_pix;
    logic [11:0] act_pix;
    int          exp_cur;

    always #5 CLK = ~CLK;

    arcade_game_selector #(.NUM_GAMES(NG), .COLOR_W(CW), .SLOT_H(48), .MENU_Y0(64)) dut (
        .CLK(CLK), .RST_BTN(RST_BTN), .x(x), .y(y),
        .key_up_n(keys_n[0]), .key_down_n(keys_n[1]), .key_sel_n(keys_n[2]), .key_back_n(keys_n[3]),
        .game_done(game_done), .game_rgb(game_rgb), .game_start(game_start), .cur_sel(cur_sel),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [11:0] menu_model(input int px, input int py, input int cur);
        if (px < 160 || px >= 480) return 12'h000;
        for (int i = 0; i < NG; i++) begin
            if (py >= 64 + i * 48 && py < 64 + i * 48 + 40) return (i == cur) ? 12'hFFF : 12'h008;
        end
        return 12'h000;
    endfunction

    function automatic int cursor_model(input int cur, input bit down);
`ifdef SELECTOR_WRAP_EN
        if (down) return (cur == NG - 1) ? 0 : cur + 1;
        return (cur == 0) ? NG - 1 : cur - 1;
`else
        if (down) return (cur == NG - 1) ? NG - 1 : cur + 1;
        return (cur == 0) ? 0 : cur - 1;
`endif
    endfunction

    task automatic drive_pixel(input int px, input int py, input logic [11:0] exp);
        x = px[9:0];
        y = py[8:0];
        sb_q.push_back(exp);
    endtask

    task automatic press_key(input int idx, input int hold, input int gap);
        keys_n[idx] = 1'b0;
        repeat (hold) tick;
        keys_n[idx] = 1'b1;
        repeat (gap) tick;
    endtask

    // sel press/release, then wait (bounded) for the run enable of the cursor game
    task automatic launch_and_wait(input logic [NG-1:0] exp_start);
        int n;
        press_key(2, 3, 0);
        n = 0;
        while (game_start !== exp_start && n < 10) begin
            tick;
            n++;
        end
        vectors++;
        if (game_start !== exp_start) begin
            miscompares++;
            $display("FAIL launch_wait: game_start=%b required %b", game_start, exp_start);
        end
    endtask

    task automatic test_reset;
        RST_BTN = 1'b0; keys_n = 4'hF; game_done = '0; game_rgb = '0;
        x = 10'd200; y = 9'd68;
        repeat (5) tick;
        vectors++;
        if (game_start !== 4'b0000) begin miscompares++; $display("FAIL reset_start: got %b required 0000", game_start); end
        vectors++;
        if (cur_sel !== 3'd0) begin miscompares++; $display("FAIL reset_cursor: got %0d required 0", cur_sel); end
        vectors++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin miscompares++; $display("FAIL reset_vga: got %h required 000", {vga_r, vga_g, vga_b}); end
        RST_BTN = 1'b1;
        tick;
        drive_pixel(200, 68, 12'hFFF);
        tick;
        exp_pix = sb_q.pop_front(); act_pix = {vga_r, vga_g, vga_b}; vectors++;
        if (act_pix !== exp_pix) begin miscompares++; $display("FAIL reset_pixel: got %h required %h", act_pix, exp_pix); end
    endtask

    task automatic test_menu_render(input int cur);
        int pts_x[12] = '{160, 159, 479, 480, 200, 200, 300, 300, 300, 300, 300, 420};
        int pts_y[12] = '{64, 64, 100, 100, 103, 104, 112, 111, 247, 248, 165, 63};
        for (int i = 0; i < 12; i++) begin
            drive_pixel(pts_x[i], pts_y[i], menu_model(pts_x[i], pts_y[i], cur));
            tick;
            exp_pix = sb_q.pop_front(); act_pix = {vga_r, vga_g, vga_b}; vectors++;
            if (act_pix !== exp_pix) begin
                miscompares++;
                $display("FAIL menu_pixel(%0d,%0d): got %h required %h", pts_x[i], pts_y[i], act_pix, exp_pix);
            end
        end
    endtask

    task automatic test_navigation;
        int n;
        exp_cur = 0;
        keys_n[1] = 1'b0;
        tick;
        vectors++;
        if (cur_sel !== 3'd0) begin miscompares++; $display("FAIL key_latency_1: got %0d required 0", cur_sel); end
        tick;
        vectors++;
        if (cur_sel !== 3'd0) begin miscompares++; $display("FAIL key_latency_2: got %0d required 0", cur_sel); end
        tick;
        exp_cur = cursor_model(exp_cur, 1'b1);
        vectors++;
        if (cur_sel !== exp_cur[2:0]) begin miscompares++; $display("FAIL key_latency_3: got %0d required %0d", cur_sel, exp_cur); end
        repeat (7) tick;
        keys_n[1] = 1'b1;
        repeat (10) tick;
        for (int i = 0; i < 4; i++) begin
            press_key(1, 10, 10);
            exp_cur = cursor_model(exp_cur, 1'b1);
        end
        vectors++;
        if (cur_sel !== exp_cur[2:0]) begin miscompares++; $display("FAIL nav_down5: got %0d required %0d", cur_sel, exp_cur); end
        keys_n[0] = 1'b0; keys_n[1] = 1'b0;
        repeat (10) tick;
        keys_n[0] = 1'b1; keys_n[1] = 1'b1;
        repeat (10) tick;
        vectors++;
        if (cur_sel !== exp_cur[2:0]) begin miscompares++; $display("FAIL nav_up_down_same: got %0d required %0d", cur_sel, exp_cur); end
        for (int i = 0; i < 4; i++) begin
            press_key(0, 10, 10);
            exp_cur = cursor_model(exp_cur, 1'b0);
        end
        vectors++;
        if (cur_sel !== exp_cur[2:0]) begin miscompares++; $display("FAIL nav_up4: got %0d required %0d", cur_sel, exp_cur); end
        n = 0;
        while (exp_cur != 2 && n < 8) begin
            press_key(1, 10, 10);
            exp_cur = cursor_model(exp_cur, 1'b1);
            n++;
        end
        vectors++;
        if (cur_sel !== 3'd2) begin miscompares++; $display("FAIL nav_to_2: got %0d required 2", cur_sel); end
    endtask

    task automatic test_launch;
        game_rgb = {12'hCDE, 12'h567, 12'h9AB, 12'h111};
        keys_n[2] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            vectors++;
            if (game_start !== 4'b0000) begin miscompares++; $display("FAIL launch_hold_start: cycle %0d got %b required 0000", i, game_start); end
        end
        drive_pixel(300, 165, 12'h000);
        tick;
        exp_pix = sb_q.pop_front(); act_pix = {vga_r, vga_g, vga_b}; vectors++;
        if (act_pix !== exp_pix) begin miscompares++; $display("FAIL launch_black: got %h required %h", act_pix, exp_pix); end
        keys_n[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            vectors++;
            if (game_start !== ((i == 2) ? 4'b0100 : 4'b0000)) begin
                miscompares++;
                $display("FAIL launch_release_%0d: got %b required %b", i, game_start, (i == 2) ? 4'b0100 : 4'b0000);
            end
        end
        drive_pixel(10, 400, 12'h567);
        tick;
        exp_pix = sb_q.pop_front(); act_pix = {vga_r, vga_g, vga_b}; vectors++;
        if (act_pix !== exp_pix) begin miscompares++; $display("FAIL run_rgb: got %h required %h", act_pix, exp_pix); end
        game_rgb[24 +: 12] = 12'hA3C;
        drive_pixel(300, 165, 12'hA3C);
        tick;
        exp_pix = sb_q.pop_front(); act_pix = {vga_r, vga_g, vga_b}; vectors++;
        if (act_pix !== exp_pix) begin miscompares++; $display("FAIL run_rgb_change: got %h required %h", act_pix, exp_pix); end
        game_rgb[24 +: 12] = 12'h567;
    endtask

    task automatic test_done;
        game_done[1] = 1'b1;
        repeat (5) tick;
        vectors++;
        if (game_start !== 4'b0100) begin miscompares++; $display("FAIL other_done_ignored: got %b required 0100", game_start); end
        game_done[1] = 1'b0;
        game_done[2] = 1'b1;
        tick;
        vectors++;
        if (game_start !== 4'b0000) begin miscompares++; $display("FAIL done_start_low: got %b required 0000", game_start); end
        drive_pixel(300, 165, 12'h000);
        tick;
        exp_pix = sb_q.pop_front(); act_pix = {vga_r, vga_g, vga_b}; vectors++;
        if (act_pix !== exp_pix) begin miscompares++; $display("FAIL exit_black: got %h required %h", act_pix, exp_pix); end
        repeat (30) tick;
        drive_pixel(300, 165, 12'h000);
        tick;
        exp_pix = sb_q.pop_front(); act_pix = {vga_r, vga_g, vga_b}; vectors++;
        if (act_pix !== exp_pix) begin miscompares++; $display("FAIL exit_hold_black: got %h required %h", act_pix, exp_pix); end
        vectors++;
        if (game_start !== 4'b0000) begin miscompares++; $display("FAIL exit_hold_start: got %b required 0000", game_start); end
        game_done[2] = 1'b0;
        tick;
        drive_pixel(300, 165, 12'hFFF);
        tick;
        exp_pix = sb_q.pop_front(); act_pix = {vga_r, vga_g, vga_b}; vectors++;
        if (act_pix !== exp_pix) begin miscompares++; $display("FAIL menu_return: got %h required %h", act_pix, exp_pix); end
        vectors++;
        if (cur_sel !== 3'd2) begin miscompares++; $display("FAIL cursor_held: got %0d required 2", cur_sel); end
    endtask

    task automatic test_back_to_back;
        int n;
        launch_and_wait(4'b0100);
        keys_n[3] = 1'b0;
        n = 0;
        while (game_start !== 4'b0000 && n < 6) begin
            tick;
            n++;
        end
        vectors++;
        if (game_start !== 4'b0000) begin miscompares++; $display("FAIL back_exit: got %b required 0000", game_start); end
        repeat (5) tick;
        keys_n[3] = 1'b1;
        repeat (5) tick;
        drive_pixel(300, 165, 12'hFFF);
        tick;
        exp_pix = sb_q.pop_front(); act_pix = {vga_r, vga_g, vga_b}; vectors++;
        if (act_pix !== exp_pix) begin miscompares++; $display("FAIL back_menu: got %h required %h", act_pix, exp_pix); end
        launch_and_wait(4'b0100);
        keys_n[3] = 1'b0;
        tick;
        tick;
        game_done[2] = 1'b1;
        tick;
        vectors++;
        if (game_start !== 4'b0000) begin miscompares++; $display("FAIL back_done_exit: got %b required 0000", game_start); end
        repeat (5) tick;
        keys_n[3] = 1'b1;
        game_done[2] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            vectors++;
            if (game_start !== 4'b0000) begin miscompares++; $display("FAIL no_relaunch: cycle %0d got %b required 0000", i, game_start); end
        end
        drive_pixel(300, 165, 12'hFFF);
        tick;
        exp_pix = sb_q.pop_front(); act_pix = {vga_r, vga_g, vga_b}; vectors++;
        if (act_pix !== exp_pix) begin miscompares++; $display("FAIL single_exit_menu: got %h required %h", act_pix, exp_pix); end
    endtask

    task automatic test_async_reset;
        launch_and_wait(4'b0100);
        #3;
        RST_BTN = 1'b0;
        #1;
        vectors++;
        if (game_start !== 4'b0000) begin miscompares++; $display("FAIL async_reset_start: got %b required 0000", game_start); end
        vectors++;
        if (cur_sel !== 3'd0) begin miscompares++; $display("FAIL async_reset_cursor: got %0d required 0", cur_sel); end
        tick;
        tick;
        RST_BTN = 1'b1;
        tick;
        drive_pixel(200, 68, 12'hFFF);
        tick;
        exp_pix = sb_q.pop_front(); act_pix = {vga_r, vga_g, vga_b}; vectors++;
        if (act_pix !== exp_pix) begin miscompares++; $display("FAIL post_reset_menu: got %h required %h", act_pix, exp_pix); end
        vectors++;
        if (game_start !== 4'b0000) begin miscompares++; $display("FAIL post_reset_start: got %b required 0000", game_start); end
    endtask

    initial begin
        test_reset;
        test_menu_render(0);
        test_navigation;
        test_menu_render(2);
        test_launch;
        test_done;
        test_back_to_back;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
